adc_frame_buffer: RTL and testbench

Parametrised multi-channel serial-to-parallel buffer for sigma-delta ADC bitstreams. It assembles NCH channels of 1-bit samples into WIDTH-bit words with a selectable bit order. It presents each completed frame behind a valid/ready handshake with sticky overrun detection, so the downstream filter can stall safely. It sits between the DIO pad register and the filter/blockram stage, replacing the fixed 4×32 buffer and its single-cycle full pulse.

---
 rtl/adc_buffer_pkg.sv | 11 +
 rtl/adc_chan_sipo.sv | 34 +++
 rtl/adc_frame_buffer.sv | 85 ++++++++
 tb/tb_adc_frame_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_buffer_pkg.sv
// Shared defaults and helpers for the ADC bitstream frame buffer.
package adc_buffer_pkg;
    localparam int ADC_NCH   = 4;
    localparam int ADC_WIDTH = 32;
    localparam int ADC_FCW   = 16;

    // Index width for a counter over n positions, never narrower than one bit.
    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/adc_chan_sipo.sv
// One channel's serial-in shift register; o_next is the word after this edge's shift.
module adc_chan_sipo
    import adc_buffer_pkg::*;
#(
    parameter int WIDTH     = ADC_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             adc_clk_i,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_next
);
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_shift;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shift = {r_word[WIDTH-2:0], i_bit};
        end else begin : g_lsb
            assign w_shift = {i_bit, r_word[WIDTH-1:1]};
        end
    endgenerate

    // Exposing the shifted value lets the top capture the completing bit without a stage.
    assign o_next = i_en ? w_shift : r_word;

    always_ff @(posedge adc_clk_i or posedge reset) begin
        if (reset)
            r_word <= '0;
        else if (i_en)
            r_word <= w_shift;
    end
endmodule

// File: rtl/adc_frame_buffer.sv
// Multi-channel sigma-delta bitstream assembler with a valid/ready frame register
// and sticky overrun flag.
module adc_frame_buffer
    import adc_buffer_pkg::*;
#(
    parameter int NCH       = ADC_NCH,
    parameter int WIDTH     = ADC_WIDTH,
    parameter bit MSB_FIRST = 1'b0,
    parameter int FCW       = ADC_FCW,
    localparam int IW       = idx_w(WIDTH)
) (
    input  logic                 adc_clk_i,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic [NCH-1:0]       adc_i,
    output logic [NCH*WIDTH-1:0] frame_o,
    output logic                 frame_valid_o,
    input  logic                 frame_ready_i,
    output logic                 overrun_o,
    input  logic                 overrun_clr_i,
    output logic [IW-1:0]        bit_idx_o,
    output logic [FCW-1:0]       frame_count_o
);
    logic [NCH*WIDTH-1:0] w_next;
    logic [NCH*WIDTH-1:0] r_frame;
    logic                 r_valid;
    logic                 r_ovr;
    logic [IW-1:0]        r_idx;
    logic [FCW-1:0]       r_cnt;
    logic                 w_complete;
    logic                 w_load;
    logic                 w_drop;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            adc_chan_sipo #(
                .WIDTH     (WIDTH),
                .MSB_FIRST (MSB_FIRST)
            ) u_sipo (
                .adc_clk_i (adc_clk_i),
                .reset     (reset),
                .i_en      (enable_i),
                .i_bit     (adc_i[k]),
                .o_next    (w_next[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign w_complete = enable_i && (r_idx == IW'(WIDTH-1));
    assign w_load     = w_complete && (!r_valid || frame_ready_i);
    assign w_drop     = w_complete && r_valid && !frame_ready_i;

    always_ff @(posedge adc_clk_i or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_frame <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (enable_i)
                r_idx <= w_complete ? '0 : r_idx + IW'(1);
            if (w_complete)
                r_cnt <= r_cnt + FCW'(1);
            if (w_load) begin
                r_frame <= w_next;
                r_valid <= 1'b1;
            end else if (frame_ready_i) begin
                r_valid <= 1'b0;
            end
            // A drop in the same edge as a clear keeps the flag set.
            if (w_drop)
                r_ovr <= 1'b1;
            else if (overrun_clr_i)
                r_ovr <= 1'b0;
        end
    end

    assign frame_o       = r_frame;
    assign frame_valid_o = r_valid;
    assign overrun_o     = r_ovr;
    assign bit_idx_o     = r_idx;
    assign frame_count_o = r_cnt;
endmodule

// File: tb/tb_adc_frame_buffer.sv
// Self-checking bench: LSB-first and MSB-first instances driven in lockstep against
// a sample-list reference model, plus directed vectors and corner sequences.
module tb_adc_frame_buffer;
    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int FCW = 16;
    localparam int FW  = NCH*W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic [NCH-1:0] a0 = '0, a1 = '0;
    logic [FW-1:0] f0, f1;
    logic v0, v1, o0, o1;
    logic [4:0] i0, i1;
    logic [FCW-1:0] c0, c1;

    always #5 clk = ~clk;

    adc_frame_buffer #(.NCH(NCH), .WIDTH(W), .MSB_FIRST(1'b0), .FCW(FCW)) dut0 (
        .adc_clk_i(clk), .reset(rst), .enable_i(en), .adc_i(a0), .frame_o(f0),
        .frame_valid_o(v0), .frame_ready_i(rdy), .overrun_o(o0), .overrun_clr_i(clr),
        .bit_idx_o(i0), .frame_count_o(c0));
    adc_frame_buffer #(.NCH(NCH), .WIDTH(W), .MSB_FIRST(1'b1), .FCW(FCW)) dut1 (
        .adc_clk_i(clk), .reset(rst), .enable_i(en), .adc_i(a1), .frame_o(f1),
        .frame_valid_o(v1), .frame_ready_i(rdy), .overrun_o(o1), .overrun_clr_i(clr),
        .bit_idx_o(i1), .frame_count_o(c1));

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: raw sample lists per channel, words assembled from bit order rules.
    bit m_bits0[NCH][W];
    bit m_bits1[NCH][W];
    int m_n = 0;
    logic [FW-1:0] m_f0 = '0, m_f1 = '0;
    logic m_valid = 1'b0, m_ovr = 1'b0;
    logic [FCW-1:0] m_cnt = '0;

    task automatic model_reset();
        m_n = 0; m_f0 = '0; m_f1 = '0; m_valid = 0; m_ovr = 0; m_cnt = '0;
    endtask

    task automatic model_step();
        bit comp, drop;
        logic [FW-1:0] w0, w1;
        comp = 0; drop = 0; w0 = '0; w1 = '0;
        if (en) begin
            for (int k = 0; k < NCH; k++) begin
                m_bits0[k][m_n] = a0[k];
                m_bits1[k][m_n] = a1[k];
            end
            if (m_n == W-1) begin
                comp = 1;
                for (int k = 0; k < NCH; k++)
                    for (int i = 0; i < W; i++) begin
                        w0[k*W + i]         = m_bits0[k][i];
                        w1[k*W + (W-1-i)]   = m_bits1[k][i];
                    end
                m_n = 0;
            end else m_n++;
        end
        if (comp) begin
            m_cnt++;
            if (!m_valid || rdy) begin m_f0 = w0; m_f1 = w1; m_valid = 1; end
            else begin drop = 1; m_ovr = 1; end
        end else if (rdy) m_valid = 0;
        if (clr && !drop) m_ovr = 0;
    endtask

    task automatic model_cmp();
        chk("m_frame0", f0, m_f0);
        chk("m_frame1", f1, m_f1);
        chk("m_valid", {v1, v0}, {m_valid, m_valid});
        chk("m_ovr", {o1, o0}, {m_ovr, m_ovr});
        chk("m_idx", {i1, i0}, {5'(m_n), 5'(m_n)});
        chk("m_cnt", {c1, c0}, {m_cnt, m_cnt});
    endtask

    task automatic cyc(input logic e, input logic [NCH-1:0] b0, input logic [NCH-1:0] b1,
                       input logic r, input logic c);
        @(negedge clk);
        en = e; a0 = b0; a1 = b1; rdy = r; clr = c;
        @(posedge clk);
        model_step();
        #1;
        model_cmp();
    endtask

    task automatic do_reset();
        en = 0; rdy = 0; clr = 0;
        #2 rst = 1;
        #1;
        chk("rst_frame", f0 | f1, '0);
        chk("rst_flags", {v0, v1, o0, o1}, '0);
        chk("rst_idx_cnt", {i0, i1, c0, c1}, '0);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    // Sends w (channel k in [k*W +: W]) LSB-first to dut0 and MSB-first to dut1.
    task automatic send_word(input logic [FW-1:0] w, input int gap_at, input int gap_len,
                             input logic r_all, input logic r_last, input logic c_last);
        logic [NCH-1:0] b0, b1;
        for (int i = 0; i < W; i++) begin
            if (i == gap_at)
                for (int g = 0; g < gap_len; g++) begin
                    cyc(1'b0, '0, '0, r_all, 1'b0);
                    chk("gap_idx", 160'(i0), 160'(gap_at));
                end
            for (int k = 0; k < NCH; k++) begin
                b0[k] = w[k*W + i];
                b1[k] = w[k*W + (W-1-i)];
            end
            if (i == W-1) cyc(1'b1, b0, b1, r_last, c_last);
            else          cyc(1'b1, b0, b1, r_all, 1'b0);
        end
    endtask

    typedef struct {
        logic [FW-1:0]  stim;
        logic [FW-1:0]  exp_frame;
        logic [FCW-1:0] exp_cnt;
    } vec_t;

    vec_t tbl[3];
    logic [FW-1:0] F1, F2, F3;

    initial begin
        tbl[0] = '{{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hA5A5_0F0F},
                   {32'h0, 32'h0, 32'hFFFF_FFFF, 32'hA5A5_0F0F}, 16'd1};
        tbl[1] = '{{32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0001, 32'h0},
                   {32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0001, 32'h0}, 16'd2};
        tbl[2] = '{{32'hFFFF_0000, 32'h0000_0001, 32'h7FFF_FFFE, 32'hC3C3_3C3C},
                   {32'hFFFF_0000, 32'h0000_0001, 32'h7FFF_FFFE, 32'hC3C3_3C3C}, 16'd3};
        F1 = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        F2 = {32'h0BAD_F00D, 32'hCAFE_BABE, 32'h0000_FFFF, 32'h8421_1248};
        F3 = {32'hFEDC_BA98, 32'h7654_3210, 32'h0F0F_F0F0, 32'h1357_9BDF};

        do_reset();

        // Directed vectors, ready held high: seamless reloads.
        for (int t = 0; t < 3; t++) begin
            send_word(tbl[t].stim, -1, 0, 1'b1, 1'b1, 1'b0);
            chk("vec_frame0", f0, tbl[t].exp_frame);
            chk("vec_frame1", f1, tbl[t].exp_frame);
            chk("vec_valid", {159'd0, v0}, 160'd1);
            chk("vec_cnt", 160'(c0), 160'(tbl[t].exp_cnt));
            chk("vec_idx_ovr", {i0, o0}, '0);
        end

        // Stall: two frames with ready low, then clear, then clear on a third drop.
        do_reset();
        send_word(F1, -1, 0, 1'b0, 1'b0, 1'b0);
        chk("stall_f1_valid", 160'(v0), 160'd1);
        chk("stall_f1_ovr", 160'(o0), 160'd0);
        send_word(F2, -1, 0, 1'b0, 1'b0, 1'b0);
        chk("stall_keep_f1", f0, F1);
        chk("stall_ovr", {o1, o0}, 2'b11);
        chk("stall_cnt", 160'(c0), 160'd2);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("ovr_clr", {o1, o0}, 2'b00);
        chk("ovr_clr_valid", 160'(v0), 160'd1);
        send_word(F3, -1, 0, 1'b0, 1'b0, 1'b1);
        chk("clr_vs_drop", {o1, o0}, 2'b11);
        chk("clr_vs_drop_f", f1, F1);

        // Accept exactly on the completing edge of frame 2.
        do_reset();
        send_word(F1, -1, 0, 1'b0, 1'b0, 1'b0);
        send_word(F2, -1, 0, 1'b0, 1'b1, 1'b0);
        chk("b2b_frame", f0, F2);
        chk("b2b_valid_ovr", {v0, o0}, 2'b10);
        chk("b2b_cnt", 160'(c0), 160'd2);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("accept_clears_valid", 160'(v0), 160'd0);

        // Enable gap of 5 cycles at bit 10: completion on cycle 37.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'(F3[i]), 4'(F3[W-1-i]), 1'b0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b0);
            chk("gap_hold_idx", 160'(i0), 160'd10);
        end
        for (int i = 10; i < W-1; i++) cyc(1'b1, 4'(F3[i]), 4'(F3[W-1-i]), 1'b0, 1'b0);
        chk("gap_not_yet", 160'(v0), 160'd0);
        cyc(1'b1, 4'(F3[W-1]), 4'(F3[0]), 1'b0, 1'b0);
        chk("gap_done", 160'(v0), 160'd1);
        chk("gap_word_ch0", 160'(f0[W-1:0]), 160'(F3[W-1:0]));
        chk("gap_word_ch0_msb", 160'(f1[W-1:0]), 160'(F3[W-1:0]));

        // Reset at bit 20 with a frame held.
        do_reset();
        send_word(F1, -1, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        chk("pre_rst_state", {v0, i0}, {1'b1, 5'd20});
        do_reset();
        for (int i = 0; i < W-1; i++) cyc(1'b1, 4'(F2[i]), 4'(F2[W-1-i]), 1'b0, 1'b0);
        chk("post_rst_not_yet", 160'(v0), 160'd0);
        cyc(1'b1, 4'(F2[W-1]), 4'(F2[0]), 1'b0, 1'b0);
        chk("post_rst_done", {v0, c0}, {1'b1, 16'd1});

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++)
            cyc(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
